ets_delay_sequencer: RTL

Sequences the phase-offset sweep for equivalent-time sampling. It drives the 8-bit delay input of the ETS clock generator, waits for the generated phase to settle, arms the offset sampler, and waits for the capture to complete. It then steps the delay and repeats until the requested number of phase bins has been captured. It sits directly upstream of ets_clkgen and beside the offset sampler's capture control.

---
 rtl/ets_delay_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ets_delay_sequencer.sv
// ETS phase-offset sweep sequencer: steps the clkgen delay code,
// waits for settling, arms the sampler and waits for each capture.
module ets_delay_sequencer #(
    parameter int DELAY_WIDTH   = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DELAY_WIDTH-1:0] delay_step,
    input  logic [DELAY_WIDTH-1:0] delay_count,
    input  logic                   capture_done,
    output logic [DELAY_WIDTH-1:0] delay,
    output logic [DELAY_WIDTH-1:0] phase_index,
    output logic                   arm,
    output logic                   busy,
    output logic                   sweep_done
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ARM,
        S_WAIT_CAPTURE,
        S_ADVANCE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
    logic [DELAY_WIDTH-1:0] idx_q, idx_d;
    logic [DELAY_WIDTH-1:0] step_q, step_d;
    logic [DELAY_WIDTH-1:0] count_q, count_d;
    logic                   done_q, done_d;
    logic                   last_bin;

    assign last_bin = (idx_q == count_q - DELAY_WIDTH'(1));

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            delay_q <= '0;
            idx_q   <= '0;
            step_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update; abort outranks every other input
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        idx_d   = idx_q;
        step_d  = step_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            delay_d = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        step_d  = delay_step;
                        count_d = delay_count;
                        delay_d = '0;
                        idx_d   = '0;
                        if (delay_count != '0) begin
                            state_d = S_SETTLE;
                            cnt_d   = RELOAD;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = S_ARM;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_ARM: begin
                    state_d = S_WAIT_CAPTURE;
                end
                S_WAIT_CAPTURE: begin
                    if (capture_done) begin
                        state_d = S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (last_bin) begin
                        state_d = S_IDLE;
                        delay_d = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                        cnt_d   = RELOAD;
                        delay_d = delay_q + step_q;
                        idx_d   = idx_q + DELAY_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        arm         = (state_q == S_ARM);
        busy        = (state_q != S_IDLE);
        sweep_done  = done_q;
        delay       = delay_q;
        phase_index = idx_q;
    end

endmodule
